// File: rtl/dct_pkg.sv
// Shared definitions for the 2-D DCT datapath: coefficient geometry, block-size
// codes and the code-to-length mapping used by the 1-D stages and the transpose buffer.
package dct_pkg;

    localparam int unsigned COEF_W = 16;
    localparam int unsigned MAX_N  = 32;

    typedef enum logic [1:0] {
        SZ4  = 2'd0,
        SZ8  = 2'd1,
        SZ16 = 2'd2,
        SZ32 = 2'd3
    } size_e;

    // Transform length L for a size code: 4 << code.
    function automatic int unsigned size_len(input size_e code);
        return 32'd4 << code;
    endfunction

endpackage

// File: rtl/transpose_buffer.sv
// Single-bank transpose buffer between the two 1-D DCT passes: fills an L x L block
// row by row, then drains it column by column; no double buffering.
module transpose_buffer #(
    parameter int unsigned COEF_W = dct_pkg::COEF_W,
    parameter int unsigned MAX_N  = dct_pkg::MAX_N
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MAX_N*COEF_W-1:0]   in_row,
    input  logic [1:0]                in_N,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MAX_N*COEF_W-1:0]   out_col,
    output logic [1:0]                out_N
);
    import dct_pkg::*;

    localparam int unsigned ROW_W = MAX_N * COEF_W;
    localparam int unsigned CNT_W = $clog2(MAX_N);

    typedef enum logic {
        StFill  = 1'b0,
        StDrain = 1'b1
    } state_e;

    state_e             r_state;
    logic [CNT_W-1:0]   r_row_cnt;
    logic [CNT_W-1:0]   r_col_cnt;
    size_e              r_blk_N;
    logic [COEF_W-1:0]  r_mem [MAX_N][MAX_N];

    logic               w_in_hs;
    logic               w_out_hs;
    size_e              w_row_N;
    logic [CNT_W-1:0]   w_last_row;
    logic [CNT_W-1:0]   w_last_col;

    always_comb begin
        w_in_hs    = in_valid && (r_state == StFill);
        w_out_hs   = out_ready && (r_state == StDrain);
        // Row 0 defines the block size; later rows use the latched code.
        w_row_N    = (r_row_cnt == '0) ? size_e'(in_N) : r_blk_N;
        w_last_row = CNT_W'(size_len(w_row_N) - 32'd1);
        w_last_col = CNT_W'(size_len(r_blk_N) - 32'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StFill;
            r_row_cnt <= '0;
            r_col_cnt <= '0;
            r_blk_N   <= SZ4;
        end else begin
            unique case (r_state)
                StFill: begin
                    if (w_in_hs) begin
                        if (r_row_cnt == '0) begin
                            r_blk_N <= size_e'(in_N);
                        end
                        if (r_row_cnt == w_last_row) begin
                            r_row_cnt <= '0;
                            r_col_cnt <= '0;
                            r_state   <= StDrain;
                        end else begin
                            r_row_cnt <= r_row_cnt + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (w_out_hs) begin
                        if (r_col_cnt == w_last_col) begin
                            r_col_cnt <= '0;
                            r_state   <= StFill;
                        end else begin
                            r_col_cnt <= r_col_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= StFill;
            endcase
        end
    end

    // Whole rows are written; lanes beyond L are never read back for this block.
    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            for (int unsigned k = 0; k < MAX_N; k++) begin
                r_mem[r_row_cnt][k] <= in_row[ROW_W-1-COEF_W*k -: COEF_W];
            end
        end
    end

    assign in_ready  = (r_state == StFill);
    assign out_valid = (r_state == StDrain);

    always_comb begin
        out_col = '0;
        out_N   = '0;
        if (r_state == StDrain) begin
            out_N = r_blk_N;
            for (int unsigned j = 0; j < MAX_N; j++) begin
                if (j < size_len(r_blk_N)) begin
                    out_col[ROW_W-1-COEF_W*j -: COEF_W] = r_mem[j][r_col_cnt];
                end
            end
        end
    end

endmodule

// File: tb/tb_transpose_buffer.sv
// Self-checking bench for transpose_buffer: per-cycle comparison against a block-level
// matrix model, directed pattern blocks with closed-form expectations, and random traffic.
module tb_transpose_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_row;
    logic [1:0]   in_N;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_col;
    logic [1:0]   out_N;

    int n_vec = 0;
    int n_err = 0;
    int rdy_mode = 0;

    transpose_buffer #(
        .COEF_W (16),
        .MAX_N  (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .in_N      (in_N),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col),
        .out_N     (out_N)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timeout waiting for handshake", name);
    endtask

    // Block-level model: a matrix, a fill/drain mode and row/column progress.
    logic [15:0] m_mat [32][32];
    bit          m_init = 0;
    bit          m_fill = 1;
    int          m_rows = 0;
    int          m_cols = 0;
    int          m_N    = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1;
            m_fill = 1;
            m_rows = 0;
            m_cols = 0;
            m_N    = 0;
        end else if (m_init) begin
            if (m_fill) begin
                if (in_valid) begin
                    if (m_rows == 0) m_N = int'(in_N);
                    for (int k = 0; k < (4 << m_N); k++) m_mat[m_rows][k] = in_row[511-16*k -: 16];
                    m_rows++;
                    if (m_rows == (4 << m_N)) begin
                        m_fill = 0;
                        m_rows = 0;
                        m_cols = 0;
                    end
                end
            end else if (out_ready) begin
                m_cols++;
                if (m_cols == (4 << m_N)) begin
                    m_fill = 1;
                    m_cols = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [511:0] e;
        if (m_init) begin
            e = '0;
            if (!m_fill) begin
                for (int j = 0; j < (4 << m_N); j++) e[511-16*j -: 16] = m_mat[j][m_cols];
            end
            check("in_ready",  512'(in_ready),  512'(m_fill));
            check("out_valid", 512'(out_valid), 512'(!m_fill));
            check("out_col",   out_col, e);
            check("out_N",     512'(out_N), m_fill ? 512'd0 : 512'(m_N));
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    function automatic logic [15:0] pat_val(input int pat, input int r, input int c);
        case (pat)
            0:       return 16'(16 * r + c);
            1:       return 16'(32 * r + c);
            2:       return ((r + c) % 2 == 1) ? 16'h7FFF : 16'h8000;
            default: return 16'(16'hA000 + 16 * r + c);
        endcase
    endfunction

    function automatic logic [511:0] pat_row(input int pat, input int n, input int r);
        logic [511:0] v = '0;
        for (int k = 0; k < (4 << n); k++) v[511-16*k -: 16] = pat_val(pat, r, k);
        return v;
    endfunction

    // Transposed view: lane j of column c is element (j, c).
    function automatic logic [511:0] pat_col(input int pat, input int n, input int c);
        logic [511:0] v = '0;
        for (int j = 0; j < (4 << n); j++) v[511-16*j -: 16] = pat_val(pat, j, c);
        return v;
    endfunction

    // Leaves in_valid high so a following row can be presented back to back.
    task automatic put_row(input logic [511:0] row, input logic [1:0] n);
        bit took;
        in_valid = 1'b1;
        in_row   = row;
        in_N     = n;
        for (int g = 0; g < 1000; g++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            if (took) return;
        end
        timeout("put_row");
    endtask

    task automatic send_block(input int pat, input int n, input int bad_row, input int bad_n,
                              input bit hold);
        for (int r = 0; r < (4 << n); r++) begin
            put_row(pat_row(pat, n, r), 2'((r == bad_row) ? bad_n : n));
        end
        if (!hold) begin
            in_valid = 1'b0;
            in_row   = '0;
        end
    endtask

    task automatic grab_col(output logic [511:0] col, output logic [1:0] n);
        for (int g = 0; g < 1000; g++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                col = out_col;
                n   = out_N;
                return;
            end
        end
        timeout("grab_col");
        col = '0;
        n   = '0;
    endtask

    task automatic capture_block(input int pat, input int n, input int ncols, input string name);
        logic [511:0] col;
        logic [1:0]   cn;
        for (int c = 0; c < ncols; c++) begin
            grab_col(col, cn);
            check({name, "_col"}, col, pat_col(pat, n, c));
            check({name, "_N"}, 512'(cn), 512'(n));
            if (pat == 0 && n == 0 && c == 1) begin
                check({name, "_lit_c1"}, col, {16'd1, 16'd17, 16'd33, 16'd49, 448'd0});
            end
            if (pat == 1 && n == 3 && c == 31) begin
                check({name, "_lit_c31_l31"}, 512'(col[15:0]), 512'd1023);
                check({name, "_lit_c31_l0"}, 512'(col[511:496]), 512'd31);
            end
            if (pat == 2 && c == 0) begin
                check({name, "_lit_ext"}, 512'(col[511:480]), 512'h8000_7FFF);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] row;
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_row    = '0;
        in_N      = '0;
        out_ready = 1'b0;
        rdy_mode  = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  512'(in_ready),  512'd1);
        check("rst_out_valid", 512'(out_valid), 512'd0);
        check("rst_out_col",   out_col, 512'd0);
        check("rst_out_N",     512'(out_N), 512'd0);
        @(posedge clk);
        #1;

        // N=0 basic transpose
        send_block(0, 0, -1, 0, 0);
        capture_block(0, 0, 4, "n0");
        @(posedge clk); #1;

        // N=3 with toggling backpressure
        rdy_mode = 1;
        send_block(1, 3, -1, 0, 0);
        capture_block(1, 3, 32, "n3");
        @(posedge clk); #1;

        // N=1 with a stray size code on row 3
        rdy_mode = 0;
        send_block(1, 1, 3, 0, 0);
        capture_block(1, 1, 8, "n1_stray");
        @(posedge clk); #1;

        // reset in the middle of a drain
        send_block(0, 0, -1, 0, 0);
        capture_block(0, 0, 2, "pre_rst");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", 512'(out_valid), 512'd0);
        check("post_rst_in_ready",  512'(in_ready),  512'd1);
        @(posedge clk); #1;
        send_block(0, 0, -1, 0, 0);
        capture_block(0, 0, 4, "after_rst");
        @(posedge clk); #1;

        // signed extremes
        send_block(2, 2, -1, 0, 0);
        capture_block(2, 2, 16, "extreme");
        @(posedge clk); #1;

        // in_valid held across the last-column handshake into the next block
        fork
            begin
                send_block(0, 0, -1, 0, 1);
                send_block(3, 0, -1, 0, 0);
            end
            begin
                capture_block(0, 0, 4, "hold_a");
                capture_block(3, 0, 4, "hold_b");
            end
        join
        @(posedge clk); #1;

        // random traffic, checked by the model every cycle
        rdy_mode = 2;
        for (int b = 0; b < 8; b++) begin
            n = int'($urandom_range(0, 3));
            for (int r = 0; r < (4 << n); r++) begin
                row = '0;
                for (int k = 0; k < (4 << n); k++) begin
                    case ($urandom_range(0, 9))
                        0:       row[511-16*k -: 16] = 16'h8000;
                        1:       row[511-16*k -: 16] = 16'h7FFF;
                        default: row[511-16*k -: 16] = 16'($urandom);
                    endcase
                end
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                put_row(row, 2'((r == 0) ? n : $urandom_range(0, 3)));
            end
            if ($urandom_range(0, 1) == 0) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        for (int g = 0; g < 3000 && !(m_fill && m_rows == 0); g++) @(posedge clk);
        if (!(m_fill && m_rows == 0)) timeout("final_drain");
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/transpose_buffer.md
TRANSPOSE_BUFFER -- requirements
Module: transpose_buffer

Interface
REQ-001 SHALL have parameter COEF_W, default 16: coefficient width in bits.
REQ-002 SHALL have parameter MAX_N, default 32: maximum transform length in coefficients.
REQ-003 SHALL use one clock; reset is synchronous and active-high. Ports are clk (clock) and rst (reset).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port in_valid  input  1  in_row/in_N carry a valid row.
REQ-007 SHALL have port in_ready  output  1  buffer accepts a row this cycle.
REQ-008 SHALL have port in_row  input  512  packed row from the 1-D permutation stage; lane k at bits [511-16k -: 16]; unused lanes zero.
REQ-009 SHALL have port in_N  input  2  size code: 0=4, 1=8, 2=16, 3=32 (L = 4<<N).
REQ-010 SHALL have port out_valid  output  1  out_col/out_N valid.
REQ-011 SHALL have port out_ready  input  1  downstream 2nd-pass stage accepts the column.
REQ-012 SHALL have port out_col  output  512  packed column, same lane layout as in_row.
REQ-013 SHALL have port out_N  output  2  size code of the block being drained.

Function
REQ-014 SHALL complete a handshake on a side only in a cycle where both valid and ready are 1 on that side.
REQ-015 SHALL implement an FSM with states FILL and DRAIN, plus 5-bit row_cnt, 5-bit col_cnt and a 2-bit latched size blk_N.
REQ-016 In FILL: in_ready=1, out_valid=0.
REQ-017 On each input handshake, SHALL store lanes 0..L-1 of in_row as matrix row row_cnt, then increment row_cnt.
REQ-018 SHALL latch blk_N from in_N on the handshake where row_cnt=0, and SHALL ignore in_N on every other row of the block.
REQ-019 On the handshake of row L-1, SHALL go to DRAIN with row_cnt=0 and col_cnt=0; out_valid SHALL be 1 in the next cycle (1-cycle latency).
REQ-020 In DRAIN: in_ready=0; out_col lane j = M[j][col_cnt] for j<L, and lanes j>=L = 0; out_N=blk_N.
REQ-021 While out_valid=1 and out_ready=0, out_col and out_N SHALL be held stable.
REQ-022 On each output handshake, col_cnt SHALL increment; on the handshake of column L-1, the FSM SHALL return to FILL and in_ready SHALL be 1 in the following cycle, never in the same cycle.
REQ-023 Whenever out_valid=0, out_col and out_N SHALL be 0.
REQ-024 SHALL pass values bit-exact, including signed extremes; there is no arithmetic, rounding or saturation.
REQ-025 Sustained throughput SHALL be L rows in then L columns out per block; the block has no double buffering.

Reset
REQ-026 While rst=1 at a clock edge: state=FILL, row_cnt=0, col_cnt=0, blk_N=0, out_valid=0, in_ready=1, out_col=0, out_N=0.
REQ-027 Reset during FILL or DRAIN SHALL discard the partial block; storage contents need not be cleared, because they are unobservable until refilled.

Structure
REQ-028 Shared package dct_pkg SHALL hold COEF_W, MAX_N, the size-code typedef (SZ4, SZ8, SZ16, SZ32) and a function returning L from the size code; the 1-D stages SHALL reuse these.
REQ-029 SHALL be a single module with no sub-module; storage SHALL be a MAX_N x MAX_N x COEF_W register array.

Verification
REQ-030 N=0, row r lane k = 16r+k, out_ready=1 -> 4 columns; column c lanes 0..3 = c, 16+c, 32+c, 48+c; lanes 4..31 = 0; out_N=0.
REQ-031 N=3, M[r][c] = 32r+c, out_ready toggling 1/0 -> 32 columns; column 31 lane j = 32j+31; each column held stable while stalled.
REQ-032 Block starts with N=1; in_N=0 is driven on row 3 -> 8 rows still consumed, 8 columns emitted, out_N=1.
REQ-033 rst pulsed in DRAIN after 2 columns -> next cycle out_valid=0, in_ready=1; a fresh N=0 block then transposes correctly.
REQ-034 in_valid held 1 during the last-column handshake -> no row accepted that cycle; row 0 of the next block is accepted the following cycle.
REQ-035 Lanes carrying -32768 (0x8000) and 32767 (0x7FFF) -> the same bit patterns appear at the transposed positions.
